// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl_if
// Purpose  : Bus bundle between a host and the display scan controller.
//            The host loads digit data and masks and receives frame and
//            commit strobes. The controller drives the shared decoder
//            nibble and the digit-select lines.
// Revision : 1.0 - initial release
// ============================================================================
interface display_scan_ctrl_if #(
    parameter int NB_DIGITS = 4
);
    logic                   Load;
    logic [4*NB_DIGITS-1:0] DataIn;
    logic [NB_DIGITS-1:0]   BlankMask;
    logic                   LZEnable;
    logic [3:0]             BinOut;
    logic [NB_DIGITS-1:0]   DigitSel;
    logic                   FrameTick;
    logic                   LoadAck;

    modport master (
        output Load, DataIn, BlankMask, LZEnable,
        input  BinOut, DigitSel, FrameTick, LoadAck
    );

    modport slave (
        input  Load, DataIn, BlankMask, LZEnable,
        output BinOut, DigitSel, FrameTick, LoadAck
    );
endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an NB_DIGITS-digit
//            7-segment display that shares one decoder. Each digit slot
//            starts with a blanking interval. Loaded data is double-buffered
//            and lands only on frame boundaries. Leading-zero suppression
//            and per-digit masking are supported.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int NB_DIGITS    = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CC_CA        = 0
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    display_scan_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NB_DIGITS);
    localparam logic [CNT_W-1:0]     C_SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]     C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]     C_CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0]     C_IDX_LAST   = IDX_W'(NB_DIGITS - 1);
    localparam logic [IDX_W-1:0]     C_IDX_ONE    = IDX_W'(1);
    localparam logic [NB_DIGITS-1:0] C_SEL_OFF    = {NB_DIGITS{CC_CA != 0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       SlotCnt_q, SlotCnt_d;
    logic [IDX_W-1:0]       Index_q, Index_d;
    logic [4*NB_DIGITS-1:0] Active_q, Active_d;
    logic [4*NB_DIGITS-1:0] Pending_q, Pending_d;
    logic [NB_DIGITS-1:0]   ActiveMask_q, ActiveMask_d;
    logic [NB_DIGITS-1:0]   PendingMask_q, PendingMask_d;
    logic                   PendFlag_q, PendFlag_d;
    logic [3:0]             BinOut_q, BinOut_d;
    logic [NB_DIGITS-1:0]   DigitSel_q, DigitSel_d;
    logic                   FrameTick_q, FrameTick_d;
    logic                   LoadAck_q, LoadAck_d;

    logic                   slot_wrap;
    logic                   frame_end;
    logic                   commit;
    logic                   dark;
    logic [NB_DIGITS-1:0]   upper_zero;
    logic [NB_DIGITS-1:0]   sel_onehot;

    // upper_zero[k] = every active nibble at index >= k is zero
    always_comb begin
        upper_zero = '0;
        upper_zero[NB_DIGITS-1] = (Active_q[4*NB_DIGITS-1 -: 4] == 4'h0);
        for (int k = NB_DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (Active_q[4*k +: 4] == 4'h0);
        end
    end

    // Next-state logic; outputs are computed from next-cycle slot position
    always_comb begin
        slot_wrap = (SlotCnt_q == C_SLOT_LAST);
        frame_end = slot_wrap && (Index_q == C_IDX_LAST);
        commit    = frame_end && PendFlag_q;

        SlotCnt_d = slot_wrap ? '0 : SlotCnt_q + C_CNT_ONE;
        Index_d   = Index_q;
        if (slot_wrap) begin
            Index_d = (Index_q == C_IDX_LAST) ? '0 : Index_q + C_IDX_ONE;
        end

        state_d = state_q;
        if (slot_wrap) begin
            state_d = ST_BLANK;
        end else if (SlotCnt_q == C_BLANK_LAST) begin
            state_d = ST_SHOW;
        end

        // Digit 0 is exempt from leading-zero suppression
        dark = ActiveMask_q[Index_d] ||
               (bus.LZEnable && (Index_d != '0) && upper_zero[Index_d]);

        sel_onehot = '0;
        if ((state_d == ST_SHOW) && !dark) begin
            sel_onehot[Index_d] = 1'b1;
        end
        DigitSel_d = (CC_CA != 0) ? ~sel_onehot : sel_onehot;

        // One-cycle lag on the nibble; the blank interval hides it
        BinOut_d = Active_q[{Index_q, 2'b00} +: 4];

        Pending_d     = bus.Load ? bus.DataIn    : Pending_q;
        PendingMask_d = bus.Load ? bus.BlankMask : PendingMask_q;
        Active_d      = commit ? Pending_q     : Active_q;
        ActiveMask_d  = commit ? PendingMask_q : ActiveMask_q;
        // A load on the commit edge re-arms the flag for the next frame
        PendFlag_d    = bus.Load ? 1'b1 : (commit ? 1'b0 : PendFlag_q);

        FrameTick_d = frame_end;
        LoadAck_d   = commit;
    end

    // Scan state, buffers and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_BLANK;
            SlotCnt_q     <= '0;
            Index_q       <= '0;
            Active_q      <= '0;
            Pending_q     <= '0;
            ActiveMask_q  <= '0;
            PendingMask_q <= '0;
            PendFlag_q    <= 1'b0;
            BinOut_q      <= 4'h0;
            DigitSel_q    <= C_SEL_OFF;
            FrameTick_q   <= 1'b0;
            LoadAck_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            SlotCnt_q     <= SlotCnt_d;
            Index_q       <= Index_d;
            Active_q      <= Active_d;
            Pending_q     <= Pending_d;
            ActiveMask_q  <= ActiveMask_d;
            PendingMask_q <= PendingMask_d;
            PendFlag_q    <= PendFlag_d;
            BinOut_q      <= BinOut_d;
            DigitSel_q    <= DigitSel_d;
            FrameTick_q   <= FrameTick_d;
            LoadAck_q     <= LoadAck_d;
        end
    end

    assign bus.BinOut    = BinOut_q;
    assign bus.DigitSel  = DigitSel_q;
    assign bus.FrameTick = FrameTick_q;
    assign bus.LoadAck   = LoadAck_q;
endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NB_DIGITS-digit 7-segment display that shares a single binary-to-7-segment decoder.
- Sequences one digit at a time. Feeds that digit's nibble to the shared decoder on BinOut and drives the matching digit-select line.
- Inserts a blanking interval between digits to prevent ghosting.
- Double-buffers the displayed value so updates land only on frame boundaries.
- Supports leading-zero suppression and per-digit blanking.

Parameters:
- NB_DIGITS, 4: number of multiplexed digits (2..8). Digit 0 is least significant.
- PRESCALE, 50000: clock cycles per digit slot (≥ 4).
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off. Constraint: 2 ≤ BLANK_CYCLES < PRESCALE.
- CC_CA, 0: display technology. 0 = common cathode, DigitSel active-high. 1 = common anode, DigitSel active-low.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Load  in  1  one-cycle strobe; capture DataIn/BlankMask into the pending buffer.
- DataIn  in  4*NB_DIGITS  nibble k = DataIn[4k+3:4k] = digit k.
- BlankMask  in  NB_DIGITS  bit k = 1 forces digit k dark (captured with DataIn).
- LZEnable  in  1  1 = suppress leading zeros (sampled live, not buffered).
- BinOut  out  4  nibble to the shared decoder.
- DigitSel  out  NB_DIGITS  one-hot digit enable, polarity per CC_CA.
- FrameTick  out  1  one-cycle pulse at each frame boundary.
- LoadAck  out  1  one-cycle pulse when pending data is committed to the active buffer.

Behaviour:
- Reset state (asynchronous):
  - SlotCnt = 0, Index = 0, state BLANK.
  - Active, Pending, ActiveMask and PendingMask = 0; PendFlag = 0.
  - BinOut = 0, FrameTick = 0, LoadAck = 0.
  - DigitSel all inactive: 0s if CC_CA = 0, 1s if CC_CA = 1.
  - Reset mid-slot aborts the scan immediately and discards pending data.
- Slot counter:
  - SlotCnt counts 0..PRESCALE-1, then wraps to 0 and advances Index.
  - Index wraps NB_DIGITS-1 → 0.
- FSM, two states per slot:
  - BLANK while SlotCnt < BLANK_CYCLES.
  - SHOW for SlotCnt in BLANK_CYCLES..PRESCALE-1.
  - BLANK → SHOW at SlotCnt = BLANK_CYCLES; SHOW → BLANK at slot wrap.
- BinOut:
  - Registered each cycle from Active nibble [Index], i.e. one-cycle lag.
  - BLANK_CYCLES ≥ 2 guarantees BinOut is stable before the digit is enabled.
- DigitSel:
  - Registered. Bit Index is active for exactly PRESCALE-BLANK_CYCLES consecutive cycles per slot, starting BLANK_CYCLES cycles after the slot's first cycle.
  - All bits inactive during BLANK.
  - Never more than one bit active.
- Digit dark condition: the active bit stays inactive for the whole SHOW if either:
  - ActiveMask[Index] = 1; or
  - LZEnable = 1, Index ≠ 0, and all Active nibbles with index ≥ Index are zero.
  - Digit 0 is never suppressed by LZ, only by mask.
- Load:
  - Load = 1 writes Pending/PendingMask and sets PendFlag.
  - A further Load before commit overwrites Pending. Only one LoadAck per commit.
- Frame boundary = the edge where SlotCnt wraps with Index = NB_DIGITS-1. On that edge:
  - Index ← 0.
  - FrameTick = 1 for the following cycle.
  - If PendFlag: Active ← Pending, ActiveMask ← PendingMask, PendFlag ← 0, LoadAck = 1 for the following cycle.
- Load on the frame-boundary edge:
  - The old Pending commits.
  - The new data goes into Pending with PendFlag = 1 and commits at the next frame.
- FrameTick and LoadAck are never high for more than one cycle.

Test Plan:
All scenarios use NB_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, CC_CA=0.
- Reset/idle: hold Reset 3 cycles, release → BinOut=0, DigitSel=0000 during Reset; after release DigitSel pattern 0001, 0010, 0100, 1000, each high 6 cycles after 2 dark cycles; FrameTick every 32 cycles.
- Load commit: Load with DataIn=16'h1234 mid-frame → LoadAck pulse coincides with next FrameTick; following frame BinOut=4,3,2,1 for digits 0..3, each stable ≥1 cycle before DigitSel.
- Leading zeros: DataIn=16'h0050, LZEnable=1 → digits 0,1 shown (BinOut 0, 5), digits 2,3 DigitSel stay 0. With DataIn=16'h0000 only digit 0 lights.
- Mask and polarity: BlankMask=4'b0100, DataIn=16'h8888 → digit 2 never enabled. Rerun with CC_CA=1 → DigitSel inverted (1110 … idle 1111).
- Overwrite/boundary: Load 16'hAAAA, then Load 16'hBBBB before the frame end → one LoadAck, display BBBB. Load asserted on the boundary edge → previous pending commits now, new value commits at the next FrameTick.
- Reset mid-SHOW: assert Reset at SlotCnt=5 of digit 2 → DigitSel inactive asynchronously; after release scan restarts at digit 0 with Active=0.
